// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a block-RAM controller
//
// Purpose: grants one transaction at a time to port A (CPU, read/write) or
// port B (video fetch, read-only), drives the controller's enable/done
// handshake, returns read data with a one-cycle ack to the owning port and
// aborts any transaction that waits TIMEOUT_CYCLES without mem_done.
//
// Ports:
//   clk_i, rst_n_i                   clock, asynchronous active-low reset
//   a_req_i/a_we_i/a_addr_i/a_wdata_i port A request, held until a_ack_o
//   a_ack_o, a_rdata_o               port A completion pulse and read data
//   b_req_i/b_addr_i                 port B read request
//   b_ack_o, b_rdata_o               port B completion pulse and read data
//   mem_addr_o/mem_wdata_o           controller address and write data
//   mem_read_en_o/mem_write_en_o     controller enables, high for the whole WAIT
//   mem_rdata_i, mem_done_i          controller read data and completion pulse
//   err_o                            sticky timeout flag, cleared by reset only
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        a_req_i,
   input  logic        a_we_i,
   input  logic [15:0] a_addr_i,
   input  logic [15:0] a_wdata_i,
   output logic        a_ack_o,
   output logic [15:0] a_rdata_o,
   input  logic        b_req_i,
   input  logic [15:0] b_addr_i,
   output logic        b_ack_o,
   output logic [15:0] b_rdata_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_read_en_o,
   output logic        mem_write_en_o,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_done_i,
   output logic        err_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

   state_t        state_q, state_d;
   logic          owner_b_q, owner_b_d;    // 1: port B owns the transaction
   logic          prefer_b_q, prefer_b_d;  // round-robin pointer, 0 favours A
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic [15:0]   mem_wdata_q, mem_wdata_d;
   logic          rd_en_q, rd_en_d;
   logic          wr_en_q, wr_en_d;
   logic          a_ack_q, a_ack_d;
   logic          b_ack_q, b_ack_d;
   logic [15:0]   a_rdata_q, a_rdata_d;
   logic [15:0]   b_rdata_q, b_rdata_d;
   logic          err_q, err_d;
   logic          grant_b;
   logic          finish;
   logic [15:0]   ret_data;

   // B wins only when it is the sole requester or it is B's turn.
   assign grant_b = b_req_i & (~a_req_i | prefer_b_q);
   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         owner_b_q   <= 1'b0;
         prefer_b_q  <= 1'b0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_b_q   <= owner_b_d;
         prefer_b_q  <= prefer_b_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_b_d   = owner_b_q;
      prefer_b_d  = prefer_b_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_en_d     = rd_en_q;
      wr_en_d     = wr_en_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      err_d       = err_q;
      finish      = 1'b0;
      ret_data    = mem_rdata_i;

      case (state_q)
         IDLE: begin
            if (a_req_i || b_req_i) begin
               owner_b_d  = grant_b;
               prefer_b_d = ~grant_b;
               cnt_d      = '0;
               if (grant_b) begin
                  mem_addr_d = b_addr_i;
                  rd_en_d    = 1'b1;
                  wr_en_d    = 1'b0;
               end else begin
                  mem_addr_d  = a_addr_i;
                  mem_wdata_d = a_wdata_i;
                  rd_en_d     = ~a_we_i;
                  wr_en_d     = a_we_i;
               end
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_done_i) begin
               finish = 1'b1;
            end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
               // Abort: the owner still gets an ack, with all-ones data.
               finish   = 1'b1;
               ret_data = 16'hFFFF;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
            if (finish) begin
               rd_en_d = 1'b0;
               wr_en_d = 1'b0;
               state_d = GAP;
               if (owner_b_q) begin
                  b_ack_d = 1'b1;
                  if (rd_en_q || !mem_done_i) b_rdata_d = ret_data;
               end else begin
                  a_ack_d = 1'b1;
                  if (rd_en_q || !mem_done_i) a_rdata_d = ret_data;
               end
            end
         end
         GAP: begin
            // One dead cycle so the requester can drop req and done can clear.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign a_ack_o        = a_ack_q;
   assign b_ack_o        = b_ack_q;
   assign a_rdata_o      = a_rdata_q;
   assign b_rdata_o      = b_rdata_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign mem_read_en_o  = rd_en_q;
   assign mem_write_en_o = wr_en_q;
   assign err_o          = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that sits directly upstream of the block-RAM controller. It arbitrates between the CPU port (A, read/write) and the video fetch port (B, read-only), and issues one transaction at a time on the controller's read_en/write_en/done handshake. It returns read data and a one-cycle acknowledge to the owning port, and guards each transaction with a timeout.

## Interface
- TIMEOUT_CYCLES, default 15: cycles spent in WAIT without mem_done before the transaction is aborted (≥4).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A request, level; fields held stable until a_ack
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  16  port A address
- a_wdata  in  16  port A write data
- a_ack  out  1  port A completion pulse, one cycle
- a_rdata  out  16  port A read data, valid with a_ack
- b_req  in  1  port B read request, level
- b_addr  in  16  port B address
- b_ack  out  1  port B completion pulse, one cycle
- b_rdata  out  16  port B read data, valid with b_ack
- mem_addr  out  16  address to controller
- mem_wdata  out  16  write data to controller
- mem_read_en  out  1  read request to controller
- mem_write_en  out  1  write request to controller
- mem_rdata  in  16  read data from controller
- mem_done  in  1  controller completion, one-cycle pulse
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, WAIT, GAP. Reset → IDLE.
- IDLE, any req high: grant port, latch addr/wdata/we into mem_* registers, assert exactly one of mem_read_en/mem_write_en, clear timeout counter, → WAIT. Port B is always a read.
- Both requests high in IDLE: round-robin. Grant the port not granted last. After reset the pointer favours A. A single requester is always granted, regardless of the pointer.
- WAIT, mem_done=1: deassert both enables, pulse owner's ack. On a read, load owner's rdata from mem_rdata (sampled this cycle). On a write, rdata is unchanged. → GAP.
- WAIT, counter reaches TIMEOUT_CYCLES without mem_done: deassert enables, pulse owner's ack, owner's rdata ← 16'hFFFF, err ← 1, → GAP.
- GAP: one cycle, no grant, → IDLE. This gives the requester time to drop req and lets the controller clear its done.
- Request dropped during WAIT: transaction still completes and ack still pulses. Request changes are ignored until IDLE.
- mem_done while in IDLE or GAP: ignored.
- err clears only on reset.
- Reset, asserted anytime including mid-transaction: all outputs 0 (acks, enables, mem_addr, mem_wdata, a_rdata, b_rdata, err), state IDLE, pointer → A. The in-flight transaction is dropped with no ack.

## Timing
- All outputs are registered. Enables rise the cycle after req is sampled in IDLE.
- The controller samples the enable one edge later and raises done two edges after the grant edge. The arbiter samples done on the following edge.
- Nominal latency: grant edge E0 → ack high after E3 (3 cycles). Next grant no earlier than E5.
- Enables stay high continuously from E0 to the done-sampling edge.
- Ack is high for exactly one cycle. rdata holds its value until the next ack to the same port.
- Back-to-back throughput: one transaction per 5 cycles with a 3-cycle controller.
- Timeout counter: 0 at grant, +1 per WAIT cycle. Abort on the edge where count == TIMEOUT_CYCLES.

## Test plan
- A read, addr 0x0010, controller returns 0xBEEF: mem_read_en high E0–E3, a_ack pulses one cycle after E3, a_rdata=0xBEEF, b_ack stays 0.
- A write, addr 0x0020, data 0x1234: mem_write_en high with mem_addr=0x0020 and mem_wdata=0x1234, a_ack pulse, a_rdata unchanged.
- a_req and b_req held high together for 4 transactions: grants alternate A,B,A,B; each ack is separated by ≥5 cycles; no overlap of enables.
- Controller never asserts done, TIMEOUT_CYCLES=15: enables drop after 15 WAIT cycles, b_ack pulses, b_rdata=0xFFFF, err=1 and stays 1 through subsequent successful reads.
- rst_n low mid-WAIT: all outputs 0 immediately. After release, no ack is produced for the lost transaction, and the next simultaneous request grants A first.
- Spurious mem_done while IDLE, plus b_req dropped during WAIT: no ack in IDLE; the dropped request still completes with b_ack.
